me_sad_search: RTL and testbench
================================

Name: me_sad_search

Overview:
Parametrised full-search integer motion estimation engine for the H.264 encoder. It holds one current macroblock and scans every candidate displacement in a ±RANGE window of a reference search-window memory. For each candidate it accumulates a row-parallel SAD and returns the best motion vector with its SAD. It supports optional early termination on a programmable SAD threshold and sits between the reference-window buffer and mode decision.

Parameters:
BLK, 16, macroblock edge in pixels (power of 2, 4..16)
RANGE, 8, search range; candidates dx,dy in [-RANGE,+RANGE]
PIX_W, 8, pixel width in bits
(derived) WIN = BLK+2*RANGE; AW = $clog2(WIN); SAD_W = PIX_W+2*$clog2(BLK); MV_W = $clog2(RANGE+1)+1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin search; accepted only when busy=0
early_en  in  1  enable early termination; sampled at start
sad_thresh  in  SAD_W  early-exit threshold; sampled at start
cur_wr_en  in  1  write one row of current block
cur_wr_row  in  $clog2(BLK)  row index
cur_wr_data  in  BLK*PIX_W  row pixels, pixel 0 in LSBs
ref_rd_en  out  1  reference-window read strobe
ref_rd_y  out  AW  window row
ref_rd_x  out  AW  window column of first pixel
ref_rd_data  in  BLK*PIX_W  BLK pixels from (y,x); valid exactly 1 cycle after ref_rd_en
busy  out  1  search in progress
done  out  1  one-cycle pulse, results valid
best_mvx  out  MV_W  signed best dx
best_mvy  out  MV_W  signed best dy
best_sad  out  SAD_W  SAD of best candidate
early_exit  out  1  last search ended on threshold

Behaviour:
- Reset values: ref_rd_en=0, ref_rd_x=ref_rd_y=0, busy=0, done=0, best_mvx=best_mvy=0, best_sad=0, early_exit=0. Current-block storage is not reset.
- Reset asserted mid-search: the search aborts immediately, outputs take their reset values, and no done pulse is produced.
- FSM states are IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on start. In the acceptance cycle, early_en and sad_thresh are latched, best_sad is internally preset to all-ones, and busy rises the next cycle.
- cur_wr_en is honoured only while busy=0. It is ignored during a search, so the block stays stable.
- start while busy=1 is ignored.
- RUN: one read per cycle, back-to-back with no bubbles. Candidates go in raster order: dy outer, dx inner, each -RANGE to +RANGE. Rows r=0..BLK-1 within a candidate.
- Read address: ref_rd_y = dy+RANGE+r, ref_rd_x = dx+RANGE.
- Pipeline: read issue at t; data at t+1; the BLK absolute differences are summed through an adder tree into a row-SAD register at t+2. The candidate accumulator adds row-SADs; the candidate completes when row BLK-1 is accumulated.
- All arithmetic is unsigned with no saturation. SAD_W holds the maximum BLK*BLK*(2^PIX_W-1).
- Compare at candidate completion: replace best if cand_sad < best_sad, strictly. On ties the earliest candidate in raster order wins. The first candidate always replaces the preset.
- Early exit: if early_en and cand_sad < sad_thresh, that candidate becomes the best, early_exit is set, ref_rd_en drops the next cycle, and row data already in flight is discarded.
- RUN → DRAIN after the final read or an early exit. DRAIN lasts until the pipeline is empty, then moves to DONE.
- DONE: done=1 for one cycle with results updated the same cycle; busy=0 from that same cycle; then IDLE.
- Results hold until the next accepted start. early_exit clears at start.
- Full-search latency: (2*RANGE+1)^2*BLK read cycles. done is asserted 3 cycles after the last ref_rd_en cycle. At defaults that is 4624 read cycles, with done at cycle 4627 after the first read.
- start may be accepted in the cycle after done.

Test Plan:
- Window random, current block copied from window offset (dx=+3,dy=-2), early_en=0 → best_mvx=3, best_mvy=-2, best_sad=0, early_exit=0, exactly 4624 ref_rd_en cycles, done 3 cycles after the last read.
- Window all 0x80, block all 0x00 → every SAD 32768 (tie), best=(-8,-8), best_sad=32768.
- Block equals window at (0,0), early_en=1, sad_thresh=1 → early_exit=1, best=(0,0), best_sad=0, ref_rd_en drops after candidate index 144, done 3 cycles later, pipelined extra rows ignored.
- start pulsed and cur_wr_en asserted during RUN → no restart, block unchanged, result identical to an undisturbed run.
- rst_n low at read cycle 1000 → all outputs at reset values, no done. A new start then completes a normal full search.
- Corner match: block copied from (+8,+8) and again from (-8,-8) with added noise of SAD 5 → best=(+8,+8), best_sad=0, confirming addressing at window corners (ref_rd_x/y reach 16 and 31 for the last row).

Source files
------------

// File: rtl/me_sad_search.sv
// Full-search integer motion estimator: scans every (dx,dy) in +/-RANGE, accumulates
// row-parallel SAD per candidate and reports the best vector, with optional threshold exit.
//
// state | meaning
// IDLE  | waiting for start; current block writable
// RUN   | issuing one reference row read per cycle in raster order
// DRAIN | reads stopped, letting the read/row-SAD pipeline empty
// DONE  | one-cycle done pulse, results published
module me_sad_search #(
   parameter int BLK   = 16,
   parameter int RANGE = 8,
   parameter int PIX_W = 8,
   localparam int WIN   = BLK + 2*RANGE,
   localparam int AW    = $clog2(WIN),
   localparam int SAD_W = PIX_W + 2*$clog2(BLK),
   localparam int MV_W  = $clog2(RANGE+1) + 1,
   localparam int RW    = $clog2(BLK)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 early_en,
   input  logic [SAD_W-1:0]     sad_thresh,
   input  logic                 cur_wr_en,
   input  logic [RW-1:0]        cur_wr_row,
   input  logic [BLK*PIX_W-1:0] cur_wr_data,
   output logic                 ref_rd_en,
   output logic [AW-1:0]        ref_rd_y,
   output logic [AW-1:0]        ref_rd_x,
   input  logic [BLK*PIX_W-1:0] ref_rd_data,
   output logic                 busy,
   output logic                 done,
   output logic [MV_W-1:0]      best_mvx,
   output logic [MV_W-1:0]      best_mvy,
   output logic [SAD_W-1:0]     best_sad,
   output logic                 early_exit
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [AW-1:0]   LAST_O = AW'(2*RANGE);
   localparam logic [RW-1:0]   LAST_R = RW'(BLK-1);
   localparam logic [MV_W-1:0] MV_OFS = MV_W'(RANGE);

   state_t               state, state_nxt;
   logic [BLK*PIX_W-1:0] cur_mem [BLK];
   logic [AW-1:0]        ox, oy;
   logic [RW-1:0]        r;
   logic                 lat_early;
   logic [SAD_W-1:0]     lat_thresh;
   logic                 p1_v, p1_last, p2_v, p2_last;
   logic [AW-1:0]        p1_ox, p1_oy, p2_ox, p2_oy, run_ox, run_oy;
   logic [RW-1:0]        p1_r;
   logic [SAD_W-1:0]     row_sum, row_sad, acc, run_sad, cand_sad;
   logic                 kill, accept, last_read, cand_ok, hit, take;

   function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
      return (a > b) ? a - b : b - a;
   endfunction

   assign accept    = (state == S_IDLE) && start;
   assign ref_rd_en = (state == S_RUN);
   assign busy      = (state == S_RUN) || (state == S_DRAIN);
   assign done      = (state == S_DONE);
   assign ref_rd_x  = ox;
   assign ref_rd_y  = oy + AW'(r);
   assign last_read = (ox == LAST_O) && (oy == LAST_O) && (r == LAST_R);
   assign cand_sad  = acc + row_sad;
   // kill blocks rows that were already in flight when the threshold was hit
   assign cand_ok   = p2_v && p2_last && !kill;
   assign hit       = cand_ok && lat_early && (cand_sad < lat_thresh);
   assign take      = hit || (cand_ok && (cand_sad < run_sad));

   always_comb begin
      row_sum = '0;
      for (int i = 0; i < BLK; i++)
         row_sum = row_sum + SAD_W'(absdiff(ref_rd_data[i*PIX_W +: PIX_W], cur_mem[p1_r][i*PIX_W +: PIX_W]));
   end

   always_ff @(posedge clk) begin
      if (cur_wr_en && !busy)
         cur_mem[cur_wr_row] <= cur_wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (last_read || hit) state_nxt = S_DRAIN;
         S_DRAIN: if (!p1_v) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ox <= '0; oy <= '0; r <= '0;
         lat_early <= 1'b0; lat_thresh <= '0;
         p1_v <= 1'b0; p1_last <= 1'b0; p1_ox <= '0; p1_oy <= '0; p1_r <= '0;
         p2_v <= 1'b0; p2_last <= 1'b0; p2_ox <= '0; p2_oy <= '0; row_sad <= '0;
         acc <= '0; run_sad <= '0; run_ox <= '0; run_oy <= '0; kill <= 1'b0;
         best_mvx <= '0; best_mvy <= '0; best_sad <= '0; early_exit <= 1'b0;
      end else begin
         p1_v    <= ref_rd_en;
         p1_last <= (r == LAST_R);
         p1_ox   <= ox;
         p1_oy   <= oy;
         p1_r    <= r;
         p2_v    <= p1_v;
         p2_last <= p1_last;
         p2_ox   <= p1_ox;
         p2_oy   <= p1_oy;
         row_sad <= row_sum;
         if (accept) begin
            ox <= '0; oy <= '0; r <= '0;
            lat_early  <= early_en;
            lat_thresh <= sad_thresh;
            acc <= '0; run_sad <= '1; run_ox <= '0; run_oy <= '0;
            kill <= 1'b0; early_exit <= 1'b0;
         end else begin
            if (ref_rd_en && !last_read) begin
               if (r == LAST_R) begin
                  r <= '0;
                  if (ox == LAST_O) begin
                     ox <= '0;
                     oy <= oy + AW'(1);
                  end else begin
                     ox <= ox + AW'(1);
                  end
               end else begin
                  r <= r + RW'(1);
               end
            end
            if (p2_v && !kill)
               acc <= p2_last ? '0 : cand_sad;
            if (take) begin
               run_sad <= cand_sad;
               run_ox  <= p2_ox;
               run_oy  <= p2_oy;
            end
            if (hit)
               kill <= 1'b1;
            if (state_nxt == S_DONE) begin
               best_sad   <= take ? cand_sad : run_sad;
               best_mvx   <= MV_W'(take ? p2_ox : run_ox) - MV_OFS;
               best_mvy   <= MV_W'(take ? p2_oy : run_oy) - MV_OFS;
               early_exit <= kill || hit;
            end
         end
      end
   end

endmodule

// File: tb/tb_me_sad_search.sv
// Directed bench for me_sad_search: a reference model computes every candidate SAD
// from plain arrays and a negedge monitor checks addresses, timing and results.
module tb_me_sad_search;
   localparam int NCAND = 17;
   localparam int FULL_READS = NCAND*NCAND*16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         early_en = 1'b0;
   logic [15:0]  sad_thresh = '0;
   logic         cur_wr_en = 1'b0;
   logic [3:0]   cur_wr_row = '0;
   logic [127:0] cur_wr_data = '0;
   logic         ref_rd_en;
   logic [4:0]   ref_rd_y, ref_rd_x;
   logic [127:0] ref_rd_data = '0;
   logic         busy, done;
   logic [4:0]   best_mvx, best_mvy;
   logic [15:0]  best_sad;
   logic         early_exit;

   me_sad_search dut (
      .clk(clk), .rst_n(rst_n), .start(start), .early_en(early_en), .sad_thresh(sad_thresh),
      .cur_wr_en(cur_wr_en), .cur_wr_row(cur_wr_row), .cur_wr_data(cur_wr_data),
      .ref_rd_en(ref_rd_en), .ref_rd_y(ref_rd_y), .ref_rd_x(ref_rd_x), .ref_rd_data(ref_rd_data),
      .busy(busy), .done(done), .best_mvx(best_mvx), .best_mvy(best_mvy),
      .best_sad(best_sad), .early_exit(early_exit)
   );

   always #5 clk = ~clk;

   int win [32][32];
   int blk [16][16];
   int n_checks = 0, n_fail = 0, cyc = 0;
   int exp_mvx, exp_mvy, exp_sad, exp_early, exp_reads;
   bit expect_done = 1'b0, done_seen = 1'b0, prev_done = 1'b0;
   int rd_cnt = 0, addr_err = 0, last_rd = 0;
   bit req_v = 1'b0;
   int req_x = 0, req_y = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // reference window memory: row returned one cycle after the strobe
   always @(negedge clk) begin
      req_v = ref_rd_en;
      req_x = int'(ref_rd_x);
      req_y = int'(ref_rd_y);
   end

   always @(posedge clk) begin
      if (req_v) begin : rd
         logic [127:0] row;
         for (int c = 0; c < 16; c++) row[c*8 +: 8] = 8'(win[req_y][req_x+c]);
         ref_rd_data <= row;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         rd_cnt = 0;
         prev_done = 1'b0;
      end else begin
         if (ref_rd_en) begin : addr
            int cd;
            cd = rd_cnt / 16;
            if (rd_cnt >= FULL_READS || int'(ref_rd_y) != cd/NCAND + rd_cnt%16 || int'(ref_rd_x) != cd%NCAND)
               addr_err++;
            rd_cnt++;
            last_rd = cyc;
         end
         if (done) begin
            chk("done_expected", expect_done, 1);
            if (expect_done) begin
               chk("best_mvx", int'($signed(best_mvx)), exp_mvx);
               chk("best_mvy", int'($signed(best_mvy)), exp_mvy);
               chk("best_sad", best_sad, exp_sad);
               chk("early_exit", early_exit, exp_early);
               chk("read_count", rd_cnt, exp_reads);
               chk("done_delay", cyc - last_rd, 3);
               chk("addr_seq_errors", addr_err, 0);
               chk("busy_at_done", busy, 0);
               done_seen = 1'b1;
               expect_done = 1'b0;
            end
            chk("done_width", prev_done, 0);
         end
         prev_done = done;
      end
   end

   task automatic model(input bit en, input int thr);
      int best;
      best = 1 << 30;
      exp_early = 0;
      exp_reads = FULL_READS;
      for (int dyi = 0; dyi < NCAND; dyi++) begin
         for (int dxi = 0; dxi < NCAND; dxi++) begin
            int s;
            s = 0;
            for (int rr = 0; rr < 16; rr++)
               for (int c = 0; c < 16; c++) begin
                  int d;
                  d = win[dyi+rr][dxi+c] - blk[rr][c];
                  s += (d < 0) ? -d : d;
               end
            if (en && s < thr) begin
               exp_mvx = dxi - 8; exp_mvy = dyi - 8; exp_sad = s; exp_early = 1;
               exp_reads = (dyi*NCAND + dxi + 1)*16 + 2;
               if (exp_reads > FULL_READS) exp_reads = FULL_READS;
               return;
            end
            if (s < best) begin
               best = s; exp_mvx = dxi - 8; exp_mvy = dyi - 8; exp_sad = s;
            end
         end
      end
   endtask

   task automatic load_block();
      logic [127:0] d;
      for (int rr = 0; rr < 16; rr++) begin
         @(negedge clk);
         for (int c = 0; c < 16; c++) d[c*8 +: 8] = 8'(blk[rr][c]);
         cur_wr_en = 1'b1; cur_wr_row = 4'(rr); cur_wr_data = d;
      end
      @(negedge clk);
      cur_wr_en = 1'b0;
   endtask

   task automatic fill_random();
      for (int y = 0; y < 32; y++)
         for (int x = 0; x < 32; x++) win[y][x] = int'($urandom_range(0, 255));
   endtask

   task automatic copy_block(input int ox, input int oy);
      for (int rr = 0; rr < 16; rr++)
         for (int c = 0; c < 16; c++) blk[rr][c] = win[oy+rr][ox+c];
   endtask

   task automatic run_search(input bit en, input int thr, input bit disturb, input int abort_at);
      @(negedge clk);
      early_en = en; sad_thresh = 16'(thr); start = 1'b1;
      addr_err = 0; rd_cnt = 0; done_seen = 1'b0; expect_done = (abort_at == 0);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         if (done_seen) break;
         if (abort_at > 0 && rd_cnt >= abort_at) begin
            rst_n = 1'b0;
            break;
         end
         if (disturb && i == 200) begin
            start = 1'b1; cur_wr_en = 1'b1; cur_wr_row = 4'd3; cur_wr_data = {16{8'hFF}};
         end else begin
            start = 1'b0; cur_wr_en = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0; cur_wr_en = 1'b0;
      if (abort_at == 0) chk("done_within_budget", done_seen, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ref_rd_en"}, ref_rd_en, 0);
      chk({tag, "_ref_rd_x"}, ref_rd_x, 0);
      chk({tag, "_ref_rd_y"}, ref_rd_y, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_best_mvx"}, best_mvx, 0);
      chk({tag, "_best_mvy"}, best_mvy, 0);
      chk({tag, "_best_sad"}, best_sad, 0);
      chk({tag, "_early_exit"}, early_exit, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;

      // block copied from (+3,-2)
      fill_random();
      copy_block(11, 6);
      load_block();
      model(1'b0, 0);
      chk("model_t1_mvx", exp_mvx, 3);
      chk("model_t1_mvy", exp_mvy, -2);
      chk("model_t1_sad", exp_sad, 0);
      chk("model_t1_reads", exp_reads, 4624);
      run_search(1'b0, 0, 1'b0, 0);

      // start and block writes during RUN must be ignored, then re-run undisturbed
      run_search(1'b0, 0, 1'b1, 0);
      run_search(1'b0, 0, 1'b0, 0);

      // flat window, zero block: all candidates tie
      for (int y = 0; y < 32; y++)
         for (int x = 0; x < 32; x++) win[y][x] = 128;
      for (int rr = 0; rr < 16; rr++)
         for (int c = 0; c < 16; c++) blk[rr][c] = 0;
      load_block();
      model(1'b0, 0);
      chk("model_t2_mvx", exp_mvx, -8);
      chk("model_t2_mvy", exp_mvy, -8);
      chk("model_t2_sad", exp_sad, 32768);
      run_search(1'b0, 0, 1'b0, 0);

      // early exit at (0,0), candidate index 144
      fill_random();
      copy_block(8, 8);
      load_block();
      model(1'b1, 1);
      chk("model_t3_mv", exp_mvx*100 + exp_mvy, 0);
      chk("model_t3_early", exp_early, 1);
      chk("model_t3_reads", exp_reads, 144*16 + 18);
      run_search(1'b1, 1, 1'b0, 0);

      // reset mid-search, then a full search
      model(1'b0, 0);
      run_search(1'b0, 0, 1'b0, 1000);
      #1;
      check_reset_outputs("abort");
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("no_done_after_abort", done_seen, 0);
      run_search(1'b0, 0, 1'b0, 0);

      // corner match at (+8,+8), noisy copy at (-8,-8)
      fill_random();
      copy_block(16, 16);
      for (int rr = 0; rr < 16; rr++)
         for (int c = 0; c < 16; c++) win[rr][c] = blk[rr][c];
      win[5][7] = (blk[5][7] > 250) ? blk[5][7] - 5 : blk[5][7] + 5;
      load_block();
      model(1'b0, 0);
      chk("model_t6_mvx", exp_mvx, 8);
      chk("model_t6_mvy", exp_mvy, 8);
      chk("model_t6_sad", exp_sad, 0);
      run_search(1'b0, 0, 1'b0, 0);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
